// File: rtl/alu_pkg.sv
// Shared types for the alu and its execute-stage sequencer.
package alu_pkg;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_XOR = 3'd4,
    ALU_SLL = 3'd5,
    ALU_SRL = 3'd6,
    ALU_SLT = 3'd7
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } seq_state_e;

endpackage

// File: rtl/alu.sv
// Combinational alu. carry is the carry-out for ADD and the borrow for SUB;
// overflow is signed overflow for ADD/SUB. Both flags are 0 for every other op.
module alu
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] i_a,
  input  logic [DATA_WIDTH-1:0] i_b,
  input  alu_op_e               i_op,
  output logic [DATA_WIDTH-1:0] o_result,
  output logic                  o_zero,
  output logic                  o_carry,
  output logic                  o_overflow
);

  localparam int SHW = $clog2(DATA_WIDTH);
  localparam int MSB = DATA_WIDTH - 1;

  logic [DATA_WIDTH:0] w_sum;
  logic [DATA_WIDTH:0] w_diff;
  logic                w_lt;

  assign w_sum  = {1'b0, i_a} + {1'b0, i_b};
  assign w_diff = {1'b0, i_a} - {1'b0, i_b};
  assign w_lt   = $signed(i_a) < $signed(i_b);

  // NOTE: every output gets a default first so no path through the case infers a latch.
  always_comb begin
    o_result   = '0;
    o_carry    = 1'b0;
    o_overflow = 1'b0;
    case (i_op)
      ALU_ADD: begin
        o_result   = w_sum[MSB:0];
        o_carry    = w_sum[DATA_WIDTH];
        o_overflow = (i_a[MSB] == i_b[MSB]) && (w_sum[MSB] != i_a[MSB]);
      end
      ALU_SUB: begin
        o_result   = w_diff[MSB:0];
        o_carry    = w_diff[DATA_WIDTH];
        o_overflow = (i_a[MSB] != i_b[MSB]) && (w_diff[MSB] != i_a[MSB]);
      end
      ALU_AND: o_result = i_a & i_b;
      ALU_OR:  o_result = i_a | i_b;
      ALU_XOR: o_result = i_a ^ i_b;
      ALU_SLL: o_result = i_a << i_b[SHW-1:0];
      ALU_SRL: o_result = i_a >> i_b[SHW-1:0];
      ALU_SLT: o_result = {{(DATA_WIDTH-1){1'b0}}, w_lt};
      default: o_result = '0;
    endcase
  end

  assign o_zero = (o_result == '0);

endmodule

// File: rtl/alu_sequencer.sv
// Execute-stage front end: accepts a request, runs the alu from latched operands
// for one cycle, then holds the registered response until the consumer takes it.
module alu_sequencer
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int TAG_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [DATA_WIDTH-1:0] req_a,
  input  logic [DATA_WIDTH-1:0] req_b,
  input  alu_op_e               req_op,
  input  logic [TAG_WIDTH-1:0]  req_tag,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_result,
  output logic                  rsp_zero,
  output logic                  rsp_carry,
  output logic                  rsp_overflow,
  output logic [TAG_WIDTH-1:0]  rsp_tag,
  output logic                  busy,
  output logic [31:0]           op_count
);

  seq_state_e            r_state;
  logic [DATA_WIDTH-1:0] r_a;
  logic [DATA_WIDTH-1:0] r_b;
  alu_op_e               r_op;
  logic [TAG_WIDTH-1:0]  r_tag;
  logic                  r_rsp_valid;
  logic [DATA_WIDTH-1:0] r_rsp_result;
  logic                  r_rsp_zero;
  logic                  r_rsp_carry;
  logic                  r_rsp_overflow;
  logic [TAG_WIDTH-1:0]  r_rsp_tag;
  logic [31:0]           r_op_count;

  logic [DATA_WIDTH-1:0] w_result;
  logic                  w_zero;
  logic                  w_carry;
  logic                  w_overflow;

  alu #(.DATA_WIDTH(DATA_WIDTH)) u_alu (
    .i_a        (r_a),
    .i_b        (r_b),
    .i_op       (r_op),
    .o_result   (w_result),
    .o_zero     (w_zero),
    .o_carry    (w_carry),
    .o_overflow (w_overflow)
  );

  // NOTE: all state is written with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= IDLE;
      r_a            <= '0;
      r_b            <= '0;
      r_op           <= ALU_ADD;
      r_tag          <= '0;
      r_rsp_valid    <= 1'b0;
      r_rsp_result   <= '0;
      r_rsp_zero     <= 1'b0;
      r_rsp_carry    <= 1'b0;
      r_rsp_overflow <= 1'b0;
      r_rsp_tag      <= '0;
      r_op_count     <= '0;
    end else if (flush) begin
      // Abort wins over both handshakes; response data keeps its last values.
      r_state     <= IDLE;
      r_rsp_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            r_a     <= req_a;
            r_b     <= req_b;
            r_op    <= req_op;
            r_tag   <= req_tag;
            r_state <= EXEC;
          end
        end
        EXEC: begin
          r_rsp_result   <= w_result;
          r_rsp_zero     <= w_zero;
          r_rsp_carry    <= w_carry;
          r_rsp_overflow <= w_overflow;
          r_rsp_tag      <= r_tag;
          r_rsp_valid    <= 1'b1;
          r_state        <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_op_count  <= r_op_count + 32'd1;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_rsp_valid <= 1'b0;
          r_state     <= IDLE;
        end
      endcase
    end
  end

  assign req_ready    = (r_state == IDLE);
  assign busy         = (r_state != IDLE);
  assign rsp_valid    = r_rsp_valid;
  assign rsp_result   = r_rsp_result;
  assign rsp_zero     = r_rsp_zero;
  assign rsp_carry    = r_rsp_carry;
  assign rsp_overflow = r_rsp_overflow;
  assign rsp_tag      = r_rsp_tag;
  assign op_count     = r_op_count;

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: directed vector table, flush/reset/backpressure
// sequences, and randomized ADD/SUB traffic against an arithmetic reference model.
module tb_alu_sequencer;
  import alu_pkg::*;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_a;
  logic [31:0] req_b;
  alu_op_e     req_op;
  logic [3:0]  req_tag;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_result;
  logic        rsp_zero;
  logic        rsp_carry;
  logic        rsp_overflow;
  logic [3:0]  rsp_tag;
  logic        busy;
  logic [31:0] op_count;

  alu_sequencer #(.DATA_WIDTH(32), .TAG_WIDTH(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_a        (req_a),
    .req_b        (req_b),
    .req_op       (req_op),
    .req_tag      (req_tag),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_result   (rsp_result),
    .rsp_zero     (rsp_zero),
    .rsp_carry    (rsp_carry),
    .rsp_overflow (rsp_overflow),
    .rsp_tag      (rsp_tag),
    .busy         (busy),
    .op_count     (op_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    alu_op_e     op;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  tag;
    logic [31:0] res;
    logic        zf;
    logic        cf;
    logic        vf;
  } vec_t;

  localparam int NVEC = 14;
  vec_t vecs [NVEC];

  int n_tests   = 0;
  int n_fail    = 0;
  int exp_count = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1 ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request and return 1 ns after the edge that accepted it.
  task automatic offer(input alu_op_e op, input logic [31:0] a, input logic [31:0] b,
                       input logic [3:0] tag);
    bit accepted;
    accepted  = 1'b0;
    req_op    = op;
    req_a     = a;
    req_b     = b;
    req_tag   = tag;
    req_valid = 1'b1;
    for (int i = 0; i < 20 && !accepted; i++) begin
      accepted = req_ready;
      tick();
    end
    req_valid = 1'b0;
    if (!accepted) check("accept_timeout", 0, 1);
  endtask

  task automatic check_rsp(input string tag_name, input logic [31:0] res, input logic zf,
                           input logic cf, input logic vf, input logic [3:0] tag);
    check({tag_name, "_result"},   rsp_result,   res);
    check({tag_name, "_zero"},     rsp_zero,     zf);
    check({tag_name, "_carry"},    rsp_carry,    cf);
    check({tag_name, "_overflow"}, rsp_overflow, vf);
    check({tag_name, "_tag"},      rsp_tag,      tag);
  endtask

  task automatic run_vec(input vec_t v);
    offer(v.op, v.a, v.b, v.tag);
    check("exec_rsp_valid", rsp_valid, 0);
    check("exec_busy", busy, 1);
    check("exec_req_ready", req_ready, 0);
    tick();
    check("latency_rsp_valid", rsp_valid, 1);
    check_rsp("vec", v.res, v.zf, v.cf, v.vf, v.tag);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    exp_count++;
    check("vec_op_count", op_count, 64'(exp_count));
    check("vec_post_rsp_valid", rsp_valid, 0);
  endtask

  // ADD/SUB reference computed with wide integer arithmetic.
  function automatic void ref_model(input bit is_sub, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] r, output logic c, output logic v);
    longint ua, ub, sa, sb, sres;
    ua = longint'(a);
    ub = longint'(b);
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (!is_sub) begin
      r    = a + b;
      c    = (ua + ub) > 64'd4294967295;
      sres = sa + sb;
    end else begin
      r    = a - b;
      c    = ua < ub;
      sres = sa - sb;
    end
    v = (sres > 64'sd2147483647) || (sres < -64'sd2147483648);
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t        v;
    logic [31:0] m_res;
    logic        m_c, m_v;
    bit          seen_valid;
    bit          got_rsp;
    alu_op_e     op;
    logic [31:0] a, b;
    logic [3:0]  tag;

    vecs[0]  = '{ALU_ADD, 32'hFFFFFFFF, 32'h00000001, 4'd3,  32'h00000000, 1'b1, 1'b1, 1'b0};
    vecs[1]  = '{ALU_ADD, 32'h7FFFFFFF, 32'h00000001, 4'd5,  32'h80000000, 1'b0, 1'b0, 1'b1};
    vecs[2]  = '{ALU_SUB, 32'h00000005, 32'h00000007, 4'd1,  32'hFFFFFFFE, 1'b0, 1'b1, 1'b0};
    vecs[3]  = '{ALU_SUB, 32'h80000000, 32'h00000001, 4'd2,  32'h7FFFFFFF, 1'b0, 1'b0, 1'b1};
    vecs[4]  = '{ALU_SUB, 32'h00001234, 32'h00001234, 4'd4,  32'h00000000, 1'b1, 1'b0, 1'b0};
    vecs[5]  = '{ALU_AND, 32'hF0F0F0F0, 32'hFF00FF00, 4'd6,  32'hF000F000, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{ALU_OR,  32'h0F0F0000, 32'h000000F0, 4'd7,  32'h0F0F00F0, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{ALU_XOR, 32'hFFFF0000, 32'hFF00FF00, 4'd8,  32'h00FFFF00, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{ALU_SLL, 32'h00000001, 32'h0000001F, 4'd9,  32'h80000000, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{ALU_SLL, 32'h00000003, 32'h00000021, 4'd10, 32'h00000006, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{ALU_SRL, 32'h80000000, 32'h00000004, 4'd11, 32'h08000000, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{ALU_SLT, 32'hFFFFFFFF, 32'h00000001, 4'd12, 32'h00000001, 1'b0, 1'b0, 1'b0};
    vecs[12] = '{ALU_SLT, 32'h00000001, 32'hFFFFFFFF, 4'd13, 32'h00000000, 1'b1, 1'b0, 1'b0};
    vecs[13] = '{ALU_SRL, 32'h00000001, 32'h00000001, 4'd14, 32'h00000000, 1'b1, 1'b0, 1'b0};

    rst       = 1'b1;
    flush     = 1'b0;
    req_valid = 1'b0;
    req_a     = '0;
    req_b     = '0;
    req_op    = ALU_ADD;
    req_tag   = '0;
    rsp_ready = 1'b0;

    // Reset state
    #12;
    check("rst_req_ready", req_ready, 1);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_op_count", op_count, 0);
    check_rsp("rst", 32'h0, 1'b0, 1'b0, 1'b0, 4'd0);
    rst = 1'b0;
    tick();

    // Directed vector table
    for (int i = 0; i < NVEC; i++) run_vec(vecs[i]);

    // Backpressure: response held for 5 cycles while a competing request is offered
    offer(ALU_ADD, 32'h100, 32'h23, 4'd15);
    tick();
    req_a     = 32'hDEAD;
    req_b     = 32'hBEEF;
    req_tag   = 4'd0;
    req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("bp_rsp_valid", rsp_valid, 1);
      check("bp_req_ready", req_ready, 0);
      check("bp_op_count", op_count, 64'(exp_count));
      check_rsp("bp", 32'h123, 1'b0, 1'b0, 1'b0, 4'd15);
      tick();
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    exp_count++;
    check("bp_op_count_after", op_count, 64'(exp_count));
    check("bp_busy_after", busy, 0);

    // Flush in EXEC with a request offered in the same cycle
    offer(ALU_ADD, 32'hAAAA, 32'h1, 4'd1);
    check("fe_busy_before", busy, 1);
    flush     = 1'b1;
    req_valid = 1'b1;
    tick();
    flush     = 1'b0;
    req_valid = 1'b0;
    check("fe_busy", busy, 0);
    check("fe_req_ready", req_ready, 1);
    check("fe_rsp_valid", rsp_valid, 0);
    check("fe_op_count", op_count, 64'(exp_count));
    check_rsp("fe_keep", 32'h123, 1'b0, 1'b0, 1'b0, 4'd15);
    tick();
    check("fe_rsp_valid_later", rsp_valid, 0);

    // Flush in IDLE blocks a simultaneous request
    req_valid = 1'b1;
    flush     = 1'b1;
    tick();
    req_valid = 1'b0;
    flush     = 1'b0;
    check("fi_no_accept", busy, 0);

    // Flush in RESP beats a simultaneous rsp_ready
    offer(ALU_ADD, 32'h9, 32'h9, 4'd2);
    tick();
    check("fr_rsp_valid_before", rsp_valid, 1);
    flush     = 1'b1;
    rsp_ready = 1'b1;
    tick();
    flush     = 1'b0;
    rsp_ready = 1'b0;
    check("fr_rsp_valid", rsp_valid, 0);
    check("fr_busy", busy, 0);
    check("fr_op_count", op_count, 64'(exp_count));
    check_rsp("fr_keep", 32'h12, 1'b0, 1'b0, 1'b0, 4'd2);

    v = '{ALU_ADD, 32'd2, 32'd3, 4'd6, 32'd5, 1'b0, 1'b0, 1'b0};
    run_vec(v);

    // Asynchronous reset between edges while in EXEC
    offer(ALU_ADD, 32'h1, 32'h1, 4'd7);
    check("re_busy_before", busy, 1);
    #2;
    rst = 1'b1;
    #1;
    check("re_rsp_valid", rsp_valid, 0);
    check("re_busy", busy, 0);
    check("re_req_ready", req_ready, 1);
    check("re_op_count", op_count, 0);
    check_rsp("re", 32'h0, 1'b0, 1'b0, 1'b0, 4'd0);
    #2;
    rst = 1'b0;
    exp_count  = 0;
    seen_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (rsp_valid) seen_valid = 1'b1;
    end
    check("re_no_response", seen_valid, 0);

    // Randomized ADD/SUB traffic with consumer stalls
    for (int n = 0; n < 1000; n++) begin
      op  = ($urandom_range(0, 1) == 0) ? ALU_ADD : ALU_SUB;
      a   = $urandom();
      b   = $urandom();
      tag = 4'($urandom_range(0, 15));
      ref_model(op == ALU_SUB, a, b, m_res, m_c, m_v);
      repeat ($urandom_range(0, 2)) tick();
      offer(op, a, b, tag);
      got_rsp = 1'b0;
      for (int i = 0; i < 10 && !got_rsp; i++) begin
        if (rsp_valid) got_rsp = 1'b1;
        else tick();
      end
      if (!got_rsp) check("rnd_rsp_timeout", 0, 1);
      repeat ($urandom_range(0, 3)) begin
        check("rnd_stall_result", rsp_result, m_res);
        check("rnd_stall_valid", rsp_valid, 1);
        tick();
      end
      check("rnd_result", rsp_result, m_res);
      check("rnd_tag", rsp_tag, tag);
      check("rnd_zero", rsp_zero, (m_res == 32'h0));
      check("rnd_carry", rsp_carry, m_c);
      check("rnd_overflow", rsp_overflow, m_v);
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      exp_count++;
    end
    check("rnd_op_count", op_count, 64'd1000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
